// File: rtl/read_stage_pkg.sv
// ----------------------------------------------------------------------------
// read_stage_pkg
// Shared widths and types for the operand-read stage.
//   D_W    : operand/result data width, taken from `D_BITS (16 if not set)
//   OP_W   : opcode field width
//   CNT_W  : stall counter width
//   RIDX_W : register index width
//   state_t: pipeline-register occupancy (EMPTY / FULL)
// ----------------------------------------------------------------------------
`ifndef D_BITS
`define D_BITS 16
`endif

package read_stage_pkg;

    localparam int D_W    = `D_BITS;
    localparam int OP_W   = 4;
    localparam int CNT_W  = 16;
    localparam int RIDX_W = 3;

    typedef logic [RIDX_W-1:0] ridx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/read_stage_hazard.sv
// ----------------------------------------------------------------------------
// read_hazard
// Combinational hazard detection for the operand-read stage.
// A load sitting in execute whose destination matches a source the incoming
// instruction actually reads forces a stall. When WB_STALL is set (no
// write-back bypass available) a same-cycle write-back to a read source
// also stalls, giving the regfile one cycle to absorb the write.
// Ports:
//   src1, src2   : incoming source registers
//   use_imm      : operand B is an immediate, so src2 is not read
//   ex_valid, ex_is_load, ex_dest : instruction currently in execute
//   wb_we, wb_dest               : write-back port
//   hazard       : stall the incoming instruction this cycle
// ----------------------------------------------------------------------------
module read_hazard
    import read_stage_pkg::*;
#(
    parameter bit WB_STALL = 1'b0
) (
    input  ridx_t src1,
    input  ridx_t src2,
    input  logic  use_imm,
    input  logic  ex_valid,
    input  logic  ex_is_load,
    input  ridx_t ex_dest,
    input  logic  wb_we,
    input  ridx_t wb_dest,
    output logic  hazard
);

    logic load_hit;
    logic wb_hit;

    assign load_hit = ex_valid & ex_is_load &
                      ((ex_dest == src1) | (~use_imm & (ex_dest == src2)));
    assign wb_hit   = wb_we &
                      ((wb_dest == src1) | (~use_imm & (wb_dest == src2)));

    assign hazard = load_hit | (WB_STALL & wb_hit);

endmodule

// File: rtl/read_stage.sv
// ----------------------------------------------------------------------------
// read_stage
// Operand-read stage between decode and execute. Drives the regfile read
// addresses straight from the decode sources, selects operands (optionally
// bypassing the same-cycle write-back), and holds them in a one-entry
// pipeline register towards execute. Counts hazard-stall cycles.
//
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high; valid, once raised, stays high with its payload stable until
// taken (or killed by flush). in_ready never depends on in_valid.
//
// Build option: READ_FWD_EN
//   defined   : write-back result is bypassed into operands A/B
//   undefined : no bypass; a write-back to a read source stalls one cycle
//
// Ports:
//   clk, rst (sync, active-low), flush
//   in_*      : decode side (valid/ready, op, dest, sources, immediate)
//   rf_src*   : regfile read addresses, rf_op* : regfile read data
//   wb_*      : write-back port
//   ex_*      : instruction currently in execute (load-use detection)
//   out_*     : registered operands to execute (valid/ready)
//   stall_cnt : saturating hazard-stall cycle count
//   dbg_state : pipeline-register occupancy, for observation
// ----------------------------------------------------------------------------
module read_stage
    import read_stage_pkg::*;
#(
    parameter int DW   = D_W,
    parameter int OPW  = OP_W,
    parameter int CNTW = CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_op,
    input  ridx_t           in_dest,
    input  ridx_t           in_src1,
    input  ridx_t           in_src2,
    input  logic            in_use_imm,
    input  logic [DW-1:0]   in_imm,
    output ridx_t           rf_src1,
    output ridx_t           rf_src2,
    input  logic [DW-1:0]   rf_op1,
    input  logic [DW-1:0]   rf_op2,
    input  logic            wb_we,
    input  ridx_t           wb_dest,
    input  logic [DW-1:0]   wb_result,
    input  logic            ex_valid,
    input  logic            ex_is_load,
    input  ridx_t           ex_dest,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  out_op,
    output ridx_t           out_dest,
    output logic [DW-1:0]   out_a,
    output logic [DW-1:0]   out_b,
    output logic [CNTW-1:0] stall_cnt,
    output state_t          dbg_state
);

`ifdef READ_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    state_t        state_q, state_d;
    logic          hazard;
    logic          accept;
    logic [DW-1:0] op_a, op_b;

    read_hazard #(.WB_STALL(!FWD_EN)) u_hazard (
        .src1       (in_src1),
        .src2       (in_src2),
        .use_imm    (in_use_imm),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_dest    (ex_dest),
        .wb_we      (wb_we),
        .wb_dest    (wb_dest),
        .hazard     (hazard)
    );

    assign rf_src1   = in_src1;
    assign rf_src2   = in_src2;
    assign out_valid = (state_q == FULL);
    assign dbg_state = state_q;

    assign in_ready = rst & ~flush & ~hazard & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // With FWD_EN cleared the bypass terms fold away and operands come
    // straight from the regfile.
    assign op_a = (FWD_EN && wb_we && (wb_dest == in_src1)) ? wb_result : rf_op1;
    assign op_b = in_use_imm ? in_imm :
                  (FWD_EN && wb_we && (wb_dest == in_src2)) ? wb_result : rf_op2;

    // Flush beats accept/drain; reset is applied in the register below.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload only moves on accept, which keeps it stable while held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_op   <= '0;
            out_dest <= '0;
            out_a    <= '0;
            out_b    <= '0;
        end else if (accept) begin
            out_op   <= in_op;
            out_dest <= in_dest;
            out_a    <= op_a;
            out_b    <= op_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_read_stage.sv
// ----------------------------------------------------------------------------
// tb_read_stage
// Self-checking bench for read_stage: directed scenarios followed by random
// traffic, every cycle compared against a behavioural reference model.
// ----------------------------------------------------------------------------
module tb_read_stage;
    import read_stage_pkg::*;

    localparam int DW   = D_W;
    localparam int OPW  = OP_W;
    localparam int CNTW = CNT_W;
    localparam longint CNT_MAX = (64'd1 << CNTW) - 1;

`ifdef READ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic            flush, in_valid, in_ready, in_use_imm;
    logic [OPW-1:0]  in_op, out_op;
    ridx_t           in_dest, in_src1, in_src2, rf_src1, rf_src2;
    ridx_t           wb_dest, ex_dest, out_dest;
    logic [DW-1:0]   in_imm, rf_op1, rf_op2, wb_result, out_a, out_b;
    logic            wb_we, ex_valid, ex_is_load, out_valid, out_ready;
    logic [CNTW-1:0] stall_cnt;
    state_t          dbg_state;

    read_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
        .in_use_imm(in_use_imm), .in_imm(in_imm),
        .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_op1(rf_op1), .rf_op2(rf_op2),
        .wb_we(wb_we), .wb_dest(wb_dest), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_dest(out_dest), .out_a(out_a), .out_b(out_b),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: what execute should currently see.
    logic            ref_valid = 1'b0;
    logic [OPW-1:0]  ref_op    = '0;
    ridx_t           ref_dest  = '0;
    logic [DW-1:0]   ref_a     = '0;
    logic [DW-1:0]   ref_b     = '0;
    longint          ref_cnt   = 0;

    // One cycle: inputs already driven after a negedge. Checks combinational
    // outputs, advances the model across the edge, checks registered outputs.
    task automatic step();
        logic          h, rdy, take;
        logic [DW-1:0] a, b;
        #1;
        h = (ex_valid && ex_is_load &&
             (ex_dest == in_src1 || (!in_use_imm && ex_dest == in_src2))) ||
            (!FWD && wb_we && (wb_dest == in_src1 || (!in_use_imm && wb_dest == in_src2)));
        rdy  = rst && !flush && !h && (!ref_valid || out_ready);
        take = in_valid && rdy;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("rf_src1", 64'(rf_src1), 64'(in_src1));
        chk("rf_src2", 64'(rf_src2), 64'(in_src2));
        a = (FWD && wb_we && wb_dest == in_src1) ? wb_result : rf_op1;
        b = in_use_imm ? in_imm : (FWD && wb_we && wb_dest == in_src2) ? wb_result : rf_op2;
        if (!rst) begin
            ref_valid = 1'b0; ref_op = '0; ref_dest = '0;
            ref_a = '0; ref_b = '0; ref_cnt = 0;
        end else begin
            if (in_valid && h && ref_cnt < CNT_MAX) ref_cnt = ref_cnt + 1;
            if (flush) ref_valid = 1'b0;
            else if (take) begin
                ref_valid = 1'b1; ref_op = in_op; ref_dest = in_dest;
                ref_a = a; ref_b = b;
            end else if (ref_valid && out_ready) ref_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(ref_valid));
        chk("dbg_state", 64'(dbg_state == FULL), 64'(ref_valid));
        chk("out_op", 64'(out_op), 64'(ref_op));
        chk("out_dest", 64'(out_dest), 64'(ref_dest));
        chk("out_a", 64'(out_a), 64'(ref_a));
        chk("out_b", 64'(out_b), 64'(ref_b));
        chk("stall_cnt", 64'(stall_cnt), 64'(ref_cnt));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        flush = 0; in_valid = 0; in_op = '0; in_dest = '0; in_src1 = '0; in_src2 = '0;
        in_use_imm = 0; in_imm = '0; rf_op1 = '0; rf_op2 = '0;
        wb_we = 0; wb_dest = '0; wb_result = '0;
        ex_valid = 0; ex_is_load = 0; ex_dest = '0; out_ready = 1;
    endtask

    task automatic drive_instr(input logic [OPW-1:0] op, input ridx_t d, input ridx_t s1,
                               input ridx_t s2, input logic [DW-1:0] v1, input logic [DW-1:0] v2);
        in_valid = 1; in_op = op; in_dest = d; in_src1 = s1; in_src2 = s2;
        rf_op1 = v1; rf_op2 = v2;
    endtask

    task automatic drive_random();
        rst        = ($urandom_range(0, 63) != 0);
        flush      = ($urandom_range(0, 15) == 0);
        in_valid   = ($urandom_range(0, 3) != 0);
        in_op      = OPW'($urandom);
        in_dest    = ridx_t'($urandom);
        in_src1    = ridx_t'($urandom);
        in_src2    = ridx_t'($urandom);
        in_use_imm = $urandom_range(0, 1) == 1;
        in_imm     = DW'($urandom);
        rf_op1     = DW'($urandom);
        rf_op2     = DW'($urandom);
        wb_we      = $urandom_range(0, 1) == 1;
        wb_dest    = ridx_t'($urandom);
        wb_result  = DW'($urandom);
        ex_valid   = $urandom_range(0, 1) == 1;
        ex_is_load = $urandom_range(0, 1) == 1;
        ex_dest    = ridx_t'($urandom);
        out_ready  = ($urandom_range(0, 3) != 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst = 0;
        @(negedge clk);
        in_valid = 1;                  // ignored while in reset
        step();
        step();
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        rst = 1;
        idle();

        // basic pass-through
        drive_instr(4'h1, 3'd1, 3'd2, 3'd3, 16'h0011, 16'h0022);
        step();
        chk("tp1_valid", 64'(out_valid), 64'd1);
        chk("tp1_a", 64'(out_a), 64'h0011);
        chk("tp1_b", 64'(out_b), 64'h0022);

        // write-back to src1 in the same cycle
        idle();
        drive_instr(4'h2, 3'd4, 3'd2, 3'd5, 16'h0011, 16'h0055);
        wb_we = 1; wb_dest = 3'd2; wb_result = 16'hBEEF;
        step();
        if (FWD) begin
            chk("fwd_a", 64'(out_a), 64'hBEEF);
        end else begin
            chk("nofwd_cnt", 64'(stall_cnt), 64'd1);
            wb_we = 0; rf_op1 = 16'hBEEF;  // regfile write has landed
            step();
            chk("nofwd_a", 64'(out_a), 64'hBEEF);
        end

        // load-use on src2
        idle();
        drive_instr(4'h3, 3'd6, 3'd1, 3'd3, 16'h0101, 16'h0303);
        ex_valid = 1; ex_is_load = 1; ex_dest = 3'd3;
        repeat (3) step();
        chk("lu_cnt_grow", 64'(stall_cnt), 64'(FWD ? 3 : 4));
        in_use_imm = 1; in_imm = 16'h1234;
        step();
        chk("lu_imm_b", 64'(out_b), 64'h1234);

        // back-pressure for 3 cycles with new instructions waiting
        idle();
        drive_instr(4'h4, 3'd2, 3'd4, 3'd5, 16'hAAAA, 16'hBBBB);
        step();
        out_ready = 0;
        drive_instr(4'h5, 3'd3, 3'd6, 3'd7, 16'hCCCC, 16'hDDDD);
        repeat (3) step();
        chk("hold_a", 64'(out_a), 64'hAAAA);
        out_ready = 1;
        step();
        chk("after_hold_a", 64'(out_a), 64'hCCCC);

        // flush while full with an incoming instruction
        idle();
        drive_instr(4'h6, 3'd1, 3'd1, 3'd1, 16'h0F0F, 16'h0F0F);
        flush = 1;
        step();
        chk("flush_valid", 64'(out_valid), 64'd0);

        // saturate the stall counter
        idle();
        drive_instr(4'h7, 3'd1, 3'd3, 3'd0, 16'h0, 16'h0);
        ex_valid = 1; ex_is_load = 1; ex_dest = 3'd3;
        repeat (65540) step();
        chk("sat_cnt", 64'(stall_cnt), 64'(CNT_MAX));
        rst = 0;
        step();
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        rst = 1;
        idle();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/read_stage.md
Name: read_stage

Overview:
- Operand-read pipeline stage between decode and execute.
- Drives register-file read addresses and captures the returned operands.
- Bypasses the write-back result arriving in the same cycle.
- Detects load-use hazards against execute and holds a registered valid/ready output to execute. Counts stall cycles for performance debug.

Parameters:
- DW, `D_BITS, operand/result data width.
- OPW, 4, opcode field width.
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- flush  in  1  branch flush; kill held and incoming instruction
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_op  in  OPW  opcode
- in_dest  in  3  destination register
- in_src1  in  3  source register 1
- in_src2  in  3  source register 2
- in_use_imm  in  1  operand B comes from in_imm, not src2
- in_imm  in  DW  immediate
- rf_src1  out  3  regfile read address 1 (= in_src1, combinational)
- rf_src2  out  3  regfile read address 2 (= in_src2, combinational)
- rf_op1  in  DW  regfile read data 1
- rf_op2  in  DW  regfile read data 2
- wb_we  in  1  write-back writes this cycle
- wb_dest  in  3  write-back register
- wb_result  in  DW  write-back data
- ex_valid  in  1  execute holds a valid instruction
- ex_is_load  in  1  that instruction is a load
- ex_dest  in  3  its destination
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_op  out  OPW  registered opcode
- out_dest  out  3  registered destination
- out_a  out  DW  operand A
- out_b  out  DW  operand B (register or immediate)
- stall_cnt  out  CNTW  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst=0 at posedge): out_valid=0, out_op=0, out_dest=0, out_a=0, out_b=0, stall_cnt=0. in_ready is 0 while rst=0.
- States:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on out_ready with no accept.
  - FULL→FULL on out_ready with accept.
- hazard = ex_valid & ex_is_load & ((ex_dest==in_src1) | (!in_use_imm & ex_dest==in_src2)).
- in_ready = rst & !flush & !hazard & (!out_valid | out_ready).
- accept = in_valid & in_ready.
- Latency: 1 cycle. Data is accepted at edge N and presented at N with out_valid=1 from N+1.
- Holding rule: while out_valid & !out_ready, all out_* hold stable.
- Operand select:
  - a = (wb_we & wb_dest==in_src1) ? wb_result : rf_op1.
  - b = in_use_imm ? in_imm : (wb_we & wb_dest==in_src2) ? wb_result : rf_op2.
  - No sign/width change; all DW bits.
- Both sources equal to wb_dest: both get wb_result.
- src1==src2: both operands are identical.
- Flush at edge:
  - out_valid←0 regardless of out_ready.
  - No accept that cycle.
  - Priority is reset > flush > accept/drain.
- stall_cnt: increments on each cycle with in_valid & hazard & rst. Saturates at all-ones; never wraps.
- Hazard asserted while FULL and out_ready=1: stage drains to EMPTY and accepts nothing that cycle.

Optional Feature:
- Macro: READ_FWD_EN.
- Defined: WB bypass exactly as above.
- Undefined:
  - Muxes are removed; operands come straight from rf_op1/rf_op2.
  - hazard additionally includes wb_we & (wb_dest==in_src1 | (!in_use_imm & wb_dest==in_src2)).
  - This stalls one cycle until the regfile write lands.
  - These cycles also count in stall_cnt.

Decomposition:
- Shared package: operand/opcode widths (from `D_BITS), register-index width 3, state enum {EMPTY, FULL}.
- One natural sub-module, read_hazard: combinational hazard detection.
  - Inputs: sources, use_imm, ex/wb fields.
  - Output: hazard.
- Forwarding muxes and the pipeline register stay in read_stage.

Test Plan:
- Reset then in_valid=1, src1=2, src2=3, rf_op1=0x0011, rf_op2=0x0022, out_ready=1 → next cycle out_valid=1, out_a=0x0011, out_b=0x0022.
- wb_we=1, wb_dest=2, wb_result=0xBEEF with src1=2, rf_op1=0x0011 → out_a=0xBEEF (READ_FWD_EN). Without the macro: in_ready=0 one cycle, stall_cnt=1, then out_a from regfile.
- ex_valid=1, ex_is_load=1, ex_dest=3, src2=3, in_use_imm=0 → in_ready=0 and stall_cnt increments each cycle. With in_use_imm=1 → no stall, out_b=in_imm.
- out_valid=1, out_ready=0 for 3 cycles with new in_valid → in_ready=0, out_* unchanged. Then out_ready=1 → next instruction appears next cycle.
- flush=1 while FULL and in_valid=1 → next cycle out_valid=0, the instruction is not captured, stall_cnt unchanged.
- Force stall_cnt to 0xFFFF by holding a hazard → remains 0xFFFF. Then rst=0 → all outputs 0.
